// File: rtl/axi4_lite_slave_pkg.sv
// Shared widths, enums and payload types for the AXI4-Lite register slave.
package axi4_lite_slave_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_REGS);
  localparam int unsigned REG_SPAN   = NUM_REGS * STRB_WIDTH;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_DATA,
    WR_WAIT_ADDR,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Write-data beat held while its address is still outstanding
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } w_beat_t;

  // Byte address falls inside the register file
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return addr < ADDR_WIDTH'(REG_SPAN);
  endfunction

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle between the team master and this slave.
interface axi4_lite_slave_if
  import axi4_lite_slave_pkg::*;
;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_slave_regs.sv
// Register file: one byte-strobed write port, one combinational read port.
module axi4_lite_slave_regs
  import axi4_lite_slave_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_mask;

  // Expand byte strobes into a bit mask
  for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_mask
    assign wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  // Storage with byte-lane merge on write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite responder with independent write and read channel FSMs.
module axi4_lite_slave
  import axi4_lite_slave_pkg::*;
(
  input logic              clk,
  input logic              rst,
  axi4_lite_slave_if.slave bus
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_commit, wr_in_range, wr_en, rd_in_range;

  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
  w_beat_t               w_beat_q, wr_beat;

  logic                  awready_d, wready_d, bvalid_d;
  logic [1:0]            bresp_d;
  logic                  arready_d, rvalid_d;
  logic [1:0]            rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d, rd_data_c;

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign b_hs  = bus.bvalid  & bus.bready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid  & bus.rready;

  // Commit uses the live beat on its handshake edge, otherwise the latched half
  assign wr_addr     = aw_hs ? bus.awaddr : aw_addr_q;
  assign wr_beat     = w_hs ? w_beat_t'({bus.wdata, bus.wstrb}) : w_beat_q;
  assign wr_in_range = addr_in_range(wr_addr);
  assign wr_commit   = (wr_next == WR_RESP) && (wr_state != WR_RESP);
  assign wr_en       = wr_commit & wr_in_range;
  assign rd_in_range = addr_in_range(bus.araddr);

  axi4_lite_slave_regs u_regs (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_addr[ADDR_LSB +: IDX_WIDTH]),
    .wr_data   (wr_beat.data),
    .wr_strb   (wr_beat.strb),
    .rd_idx    (bus.araddr[ADDR_LSB +: IDX_WIDTH]),
    .rd_data_c (rd_data_c)
  );

  // Hold whichever half of a split write arrives first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_addr_q <= '0;
      w_beat_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= bus.awaddr;
      if (w_hs)  w_beat_q  <= w_beat_t'({bus.wdata, bus.wstrb});
    end
  end

  // Write FSM state and registered write-channel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state    <= WR_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= OKAY;
    end else begin
      wr_state    <= wr_next;
      bus.awready <= awready_d;
      bus.wready  <= wready_d;
      bus.bvalid  <= bvalid_d;
      bus.bresp   <= bresp_d;
    end
  end

  // Write next-state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_RESP;
        else if (aw_hs)    wr_next = WR_WAIT_DATA;
        else if (w_hs)     wr_next = WR_WAIT_ADDR;
      end
      WR_WAIT_DATA: if (w_hs)  wr_next = WR_RESP;
      WR_WAIT_ADDR: if (aw_hs) wr_next = WR_RESP;
      WR_RESP:      if (b_hs)  wr_next = WR_IDLE;
      default:                 wr_next = WR_IDLE;
    endcase
  end

  // Write outputs decoded from the upcoming state; response fixed at commit
  always_comb begin
    awready_d = (wr_next == WR_IDLE) || (wr_next == WR_WAIT_ADDR);
    wready_d  = (wr_next == WR_IDLE) || (wr_next == WR_WAIT_DATA);
    bvalid_d  = (wr_next == WR_RESP);
    bresp_d   = bus.bresp;
    if (wr_commit) bresp_d = wr_in_range ? OKAY : SLVERR;
  end

  // Read FSM state and registered read-channel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state    <= RD_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= OKAY;
    end else begin
      rd_state    <= rd_next;
      bus.arready <= arready_d;
      bus.rvalid  <= rvalid_d;
      bus.rdata   <= rdata_d;
      bus.rresp   <= rresp_d;
    end
  end

  // Read next-state
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (r_hs)  rd_next = RD_IDLE;
      default:            rd_next = RD_IDLE;
    endcase
  end

  // Read outputs; payload captured on the AR handshake and held until accepted
  always_comb begin
    arready_d = (rd_next == RD_IDLE);
    rvalid_d  = (rd_next == RD_DATA);
    rdata_d   = bus.rdata;
    rresp_d   = bus.rresp;
    if (ar_hs) begin
      rdata_d = rd_in_range ? rd_data_c : '0;
      rresp_d = rd_in_range ? OKAY : SLVERR;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Randomized scoreboard bench for the AXI4-Lite register slave.
module tb_axi4_lite_slave;
  import axi4_lite_slave_pkg::*;

  localparam int unsigned BUDGET = 100;
  localparam int unsigned BYTES  = DATA_WIDTH / 8;

  logic clk = 1'b0;
  logic rst;

  axi4_lite_slave_if bus ();

  axi4_lite_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DATA_WIDTH-1:0] model_mem [NUM_REGS];
  logic [1:0]            exp_b [$];
  logic [DATA_WIDTH+1:0] exp_r [$];
  int b_mode = 1;  // 0 random, 1 always ready, 2 stalled
  int r_mode = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not match expectation at %0t", name, $time);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.awready, bus.wready, bus.bvalid, bus.bresp,
                bus.arready, bus.rvalid, bus.rdata, bus.rresp});
  endfunction

  // Reference model: byte-addressed word array, anything past the last word errors
  function automatic logic in_range_m(input logic [ADDR_WIDTH-1:0] addr);
    return addr < ADDR_WIDTH'(NUM_REGS * BYTES);
  endfunction

  function automatic void prep_write(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [DATA_WIDTH-1:0] data,
                                     input logic [STRB_WIDTH-1:0] strb);
    int idx;
    if (in_range_m(addr)) begin
      idx = int'(addr) / int'(BYTES);
      for (int b = 0; b < int'(BYTES); b++)
        if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endfunction

  function automatic logic [DATA_WIDTH+1:0] model_read(input logic [ADDR_WIDTH-1:0] addr);
    if (in_range_m(addr)) return {model_mem[int'(addr) / int'(BYTES)], 2'b00};
    return {{DATA_WIDTH{1'b0}}, 2'b10};
  endfunction

  // Response acceptance from the master side
  always @(posedge clk) begin
    #1;
    bus.bready = (b_mode == 1) || (b_mode == 0 && $urandom_range(0, 2) != 0);
    bus.rready = (r_mode == 1) || (r_mode == 0 && $urandom_range(0, 2) != 0);
  end

  // Monitor: pops expectations on each response handshake, checks stall stability
  logic                  b_stall_q = 1'b0;
  logic                  r_stall_q = 1'b0;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH+1:0] rpay_q;
  always @(negedge clk) begin
    if (rst) begin
      b_stall_q = 1'b0;
      r_stall_q = 1'b0;
    end else begin
      if (b_stall_q) begin
        check("bvalid_held", 64'(bus.bvalid), 64'd1);
        check("bresp_held", 64'(bus.bresp), 64'(bresp_q));
      end
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else check("bresp", 64'(bus.bresp), 64'(exp_b.pop_front()));
      end
      if (bus.bvalid && !bus.bready)
        check("b_stall_aw_w_ready", 64'({bus.awready, bus.wready}), 64'd0);
      b_stall_q = bus.bvalid && !bus.bready;
      bresp_q   = bus.bresp;

      if (r_stall_q) begin
        check("rvalid_held", 64'(bus.rvalid), 64'd1);
        check("rpayload_held", 64'({bus.rdata, bus.rresp}), 64'(rpay_q));
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else check("rdata_rresp", 64'({bus.rdata, bus.rresp}), 64'(exp_r.pop_front()));
      end
      if (bus.rvalid && !bus.rready)
        check("r_stall_arready", 64'(bus.arready), 64'd0);
      r_stall_q = bus.rvalid && !bus.rready;
      rpay_q    = {bus.rdata, bus.rresp};
    end
  end

  // Channel drivers: start at posedge+1, return at posedge+1 after the handshake edge
  task automatic send_aw(input logic [ADDR_WIDTH-1:0] addr, input int dly);
    logic hs;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    for (int n = 0; n <= int'(BUDGET); n++) begin
      @(negedge clk);
      hs = bus.awready;
      @(posedge clk);
      #1;
      if (hs) break;
      if (n == int'(BUDGET)) fail_now("aw_timeout");
    end
    bus.awvalid = 1'b0;
    bus.awaddr  = ADDR_WIDTH'($urandom);
  endtask

  task automatic send_w(input logic [DATA_WIDTH-1:0] data, input logic [STRB_WIDTH-1:0] strb,
                        input int dly);
    logic hs;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    for (int n = 0; n <= int'(BUDGET); n++) begin
      @(negedge clk);
      hs = bus.wready;
      @(posedge clk);
      #1;
      if (hs) break;
      if (n == int'(BUDGET)) fail_now("w_timeout");
    end
    bus.wvalid = 1'b0;
    bus.wdata  = DATA_WIDTH'($urandom);
    bus.wstrb  = STRB_WIDTH'($urandom);
  endtask

  task automatic send_ar(input logic [ADDR_WIDTH-1:0] addr, input int dly);
    logic hs;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    for (int n = 0; n <= int'(BUDGET); n++) begin
      @(negedge clk);
      hs = bus.arready;
      @(posedge clk);
      #1;
      if (hs) break;
      if (n == int'(BUDGET)) fail_now("ar_timeout");
    end
    bus.arvalid = 1'b0;
    bus.araddr  = ADDR_WIDTH'($urandom);
  endtask

  task automatic do_write(input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data,
                          input logic [STRB_WIDTH-1:0] strb, input int dly_aw, input int dly_w);
    prep_write(addr, data, strb);
    fork
      send_aw(addr, dly_aw);
      send_w(data, strb, dly_w);
    join
    @(negedge clk);
    check("b_latency", 64'(bus.bvalid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [ADDR_WIDTH-1:0] addr);
    exp_r.push_back(model_read(addr));
    send_ar(addr, 0);
    @(negedge clk);
    check("r_latency", 64'(bus.rvalid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n <= int'(BUDGET); n++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && exp_r.size() == 0 && !bus.bvalid && !bus.rvalid) break;
      if (n == int'(BUDGET)) begin
        fail_now("drain_timeout");
        exp_b.delete();
        exp_r.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, limit 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, w, r;
    logic [ADDR_WIDTH-1:0] a, ra;

    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    bus.awaddr  = '0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.araddr  = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) model_mem[i] = '0;

    // Reset state and ready rise on the first edge after release
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'({bus.awready, bus.wready, bus.arready}), 64'b111);

    // Reset dropped mid-write clears registers and issues no response
    do_write(32'h04, 32'hA5A5_A5A5, 4'hF, 0, 0);
    drain();
    send_aw(32'h04, 0);
    check("aw_only_waits", 64'({bus.awready, bus.wready, bus.bvalid}), 64'b010);
    rst = 1'b1;
    #1;
    check("reset_mid_write", out_vec(), 64'd0);
    for (int i = 0; i < int'(NUM_REGS); i++) model_mem[i] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_after_reset", 64'({bus.awready, bus.wready, bus.bvalid, bus.arready}), 64'b1101);
    do_read(32'h04);
    drain();

    // Basic write and read back
    do_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(32'h08);
    drain();

    // W two cycles ahead of AW
    fork
      do_write(32'h0C, 32'h1234_5678, 4'hF, 2, 0);
      begin
        @(posedge clk);
        #1;
        check("wready_low_waiting", 64'({bus.wready, bus.awready, bus.bvalid}), 64'b010);
      end
    join
    do_read(32'h0C);
    drain();

    // Partial byte strobes
    do_write(32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_write(32'h04, 32'h0000_0000, 4'b0101, 0, 0);
    do_read(32'h04);
    drain();

    // Out of range
    do_write(32'h40, 32'hCAFE_F00D, 4'hF, 0, 0);
    do_read(32'h40);
    do_read(32'h3C);
    drain();

    // Response backpressure
    b_mode = 2;
    do_write(32'h10, 32'h1111_2222, 4'hF, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("bvalid_after_stall", 64'(bus.bvalid), 64'd1);
    b_mode = 1;
    drain();
    r_mode = 2;
    do_read(32'h10);
    repeat (5) @(posedge clk);
    #1;
    check("rvalid_after_stall", 64'(bus.rvalid), 64'd1);
    r_mode = 1;
    drain();

    // Read and write commit to the same word on the same edge
    do_write(32'h00, 32'h1, 4'hF, 0, 0);
    drain();
    exp_r.push_back(model_read(32'h00));
    prep_write(32'h00, 32'h2, 4'hF);
    fork
      send_aw(32'h00, 0);
      send_w(32'h2, 4'hF, 0);
      send_ar(32'h00, 0);
    join
    drain();
    do_read(32'h00);
    drain();

    // Randomized traffic with random response backpressure
    b_mode = 0;
    r_mode = 0;
    for (int it = 0; it < 200; it++) begin
      op = int'($urandom_range(0, 3));
      a  = ADDR_WIDTH'($urandom_range(0, 17) * BYTES + $urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 9) == 0) a = ADDR_WIDTH'($urandom);
      case (op)
        0, 1: do_write(a, DATA_WIDTH'($urandom), STRB_WIDTH'($urandom),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        2: do_read(a);
        default: begin
          w  = int'($urandom_range(0, NUM_REGS - 1));
          r  = (w + 1 + int'($urandom_range(0, NUM_REGS - 2))) % int'(NUM_REGS);
          a  = ADDR_WIDTH'(w * int'(BYTES));
          ra = ADDR_WIDTH'(r * int'(BYTES));
          fork
            do_write(a, DATA_WIDTH'($urandom), STRB_WIDTH'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            do_read(ra);
          join
        end
      endcase
    end
    b_mode = 1;
    r_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
